alu_ctrl_pipe: RTL and testbench

//  Registered, parametrised ALU control decoder for the EX stage. Decodes {aluop, funct} into a
//  4-bit ALU control word behind a valid/ready pipeline register. Adds XOR/NOR/SLTU, shifts, LUI
//  and HI/LO moves. Also tracks multi-cycle mult/div occupancy and back-pressures HI/LO hazards.

---
 rtl/alu_ctrl_pipe.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control decoder for the EX stage, with a valid/ready output register and
// mult/div occupancy tracking. Optional muldiv support is enabled by defining ALU_CTRL_MULDIV_EN.
module alu_ctrl_pipe #(
    parameter int ALUOP_W  = 3,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [5:0]         funct,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         alucontrol,
    output logic               shift_var,
    output logic               is_unsigned,
    output logic               illegal,
    output logic               md_busy,
    output logic               md_done
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_NOR  = 4'b0100;
    localparam logic [3:0] CTRL_INV  = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU = 4'b1000;
    localparam logic [3:0] CTRL_SLL  = 4'b1001;
    localparam logic [3:0] CTRL_SRL  = 4'b1010;
    localparam logic [3:0] CTRL_SRA  = 4'b1011;
    localparam logic [3:0] CTRL_LUI  = 4'b1100;
`ifdef ALU_CTRL_MULDIV_EN
    localparam logic [3:0] CTRL_MULT = 4'b1101;
    localparam logic [3:0] CTRL_DIV  = 4'b1110;
    localparam logic [3:0] CTRL_HILO = 4'b1111;
`endif

    if (ALUOP_W != 3 || MULT_LAT < 1 || DIV_LAT < 1) begin : g_paramCheck
        $error("alu_ctrl_pipe: ALUOP_W must be 3 and latencies must be >= 1");
    end

    logic [3:0] decCtrl;
    logic       decShiftVar;
    logic       decUnsigned;
    logic       decIllegal;
`ifdef ALU_CTRL_MULDIV_EN
    logic       decMult;
    logic       decDiv;
    logic       decHiloMove;
`endif

    always_comb begin
        decCtrl     = CTRL_INV;
        decShiftVar = 1'b0;
        decUnsigned = 1'b0;
        decIllegal  = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
        decMult     = 1'b0;
        decDiv      = 1'b0;
        decHiloMove = 1'b0;
`endif
        case (aluop)
            3'b000: decCtrl = CTRL_ADD;
            3'b001: decCtrl = CTRL_SUB;
            3'b011: decCtrl = CTRL_AND;
            3'b100: decCtrl = CTRL_OR;
            3'b101: decCtrl = CTRL_SLT;
            3'b110: decCtrl = CTRL_LUI;
            3'b111: decCtrl = CTRL_XOR;
            3'b010: begin
                case (funct)
                    6'b100000, 6'b100001: decCtrl = CTRL_ADD;
                    6'b100010, 6'b100011: decCtrl = CTRL_SUB;
                    6'b100100:            decCtrl = CTRL_AND;
                    6'b100101:            decCtrl = CTRL_OR;
                    6'b100110:            decCtrl = CTRL_XOR;
                    6'b100111:            decCtrl = CTRL_NOR;
                    6'b101010:            decCtrl = CTRL_SLT;
                    6'b101011: begin
                        decCtrl     = CTRL_SLTU;
                        decUnsigned = 1'b1;
                    end
                    6'b000000:            decCtrl = CTRL_SLL;
                    6'b000010:            decCtrl = CTRL_SRL;
                    6'b000011:            decCtrl = CTRL_SRA;
                    6'b000100: begin
                        decCtrl     = CTRL_SLL;
                        decShiftVar = 1'b1;
                    end
                    6'b000110: begin
                        decCtrl     = CTRL_SRL;
                        decShiftVar = 1'b1;
                    end
                    6'b000111: begin
                        decCtrl     = CTRL_SRA;
                        decShiftVar = 1'b1;
                    end
`ifdef ALU_CTRL_MULDIV_EN
                    6'b011000, 6'b011001: begin
                        decCtrl     = CTRL_MULT;
                        decMult     = 1'b1;
                        decUnsigned = funct[0];
                    end
                    6'b011010, 6'b011011: begin
                        decCtrl     = CTRL_DIV;
                        decDiv      = 1'b1;
                        decUnsigned = funct[0];
                    end
                    6'b010000, 6'b010010: begin
                        decCtrl     = CTRL_HILO;
                        decHiloMove = 1'b1;
                    end
`endif
                    default:              decIllegal = 1'b1;
                endcase
            end
            default: decIllegal = 1'b1;
        endcase
    end

    logic       outValid_q, outValid_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic       shiftVar_q, shiftVar_d;
    logic       unsigned_q, unsigned_d;
    logic       illegal_q, illegal_d;
    logic       load;
    logic       mdBusy;
    logic       mdDone;

`ifdef ALU_CTRL_MULDIV_EN
    typedef enum logic {MD_IDLE, MD_BUSY} mdState_e;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    logic             outIsMd_q, outIsMd_d;
    logic             outIsDiv_q, outIsDiv_d;
    mdState_e         mdState_q, mdState_d;
    logic [CNT_W-1:0] mdCnt_q, mdCnt_d;
    logic             mdStart;
    logic             hazardBlk;

    // A hilo-class op must wait while the unit is busy or a mult/div is still waiting to leave.
    assign hazardBlk = (decMult | decDiv | decHiloMove) & (mdBusy | (outValid_q & outIsMd_q));
    assign in_ready  = (~outValid_q | out_ready) & ~flush & ~hazardBlk;
    assign mdStart   = outValid_q & out_ready & ~flush & outIsMd_q;
    assign mdBusy    = (mdState_q == MD_BUSY);
    assign mdDone    = mdBusy & (mdCnt_q == '0);

    always_comb begin
        mdState_d = mdState_q;
        mdCnt_d   = mdCnt_q;
        case (mdState_q)
            MD_IDLE: begin
                if (mdStart) begin
                    mdState_d = MD_BUSY;
                    mdCnt_d   = outIsDiv_q ? DIV_CNT : MULT_CNT;
                end
            end
            MD_BUSY: begin
                if (mdCnt_q == '0) begin
                    mdState_d = MD_IDLE;
                end else begin
                    mdCnt_d = mdCnt_q - 1'b1;
                end
            end
            default: mdState_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdState_q  <= MD_IDLE;
            mdCnt_q    <= '0;
            outIsMd_q  <= 1'b0;
            outIsDiv_q <= 1'b0;
        end else begin
            mdState_q  <= mdState_d;
            mdCnt_q    <= mdCnt_d;
            outIsMd_q  <= outIsMd_d;
            outIsDiv_q <= outIsDiv_d;
        end
    end
`else
    assign in_ready = (~outValid_q | out_ready) & ~flush;
    assign mdBusy   = 1'b0;
    assign mdDone   = 1'b0;
`endif

    assign load = in_valid & in_ready;

    // Flush wins over a same-cycle load; data fields may keep stale values once invalid.
    always_comb begin
        outValid_d = outValid_q;
        ctrl_d     = ctrl_q;
        shiftVar_d = shiftVar_q;
        unsigned_d = unsigned_q;
        illegal_d  = illegal_q;
`ifdef ALU_CTRL_MULDIV_EN
        outIsMd_d  = outIsMd_q;
        outIsDiv_d = outIsDiv_q;
`endif
        if (flush) begin
            outValid_d = 1'b0;
        end else if (load) begin
            outValid_d = 1'b1;
            ctrl_d     = decCtrl;
            shiftVar_d = decShiftVar;
            unsigned_d = decUnsigned;
            illegal_d  = decIllegal;
`ifdef ALU_CTRL_MULDIV_EN
            outIsMd_d  = decMult | decDiv;
            outIsDiv_d = decDiv;
`endif
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_q <= 1'b0;
            ctrl_q     <= CTRL_AND;
            shiftVar_q <= 1'b0;
            unsigned_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            outValid_q <= outValid_d;
            ctrl_q     <= ctrl_d;
            shiftVar_q <= shiftVar_d;
            unsigned_q <= unsigned_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out_valid   = outValid_q;
    assign alucontrol  = ctrl_q;
    assign shift_var   = shiftVar_q;
    assign is_unsigned = unsigned_q;
    assign illegal     = illegal_q;
    assign md_busy     = mdBusy;
    assign md_done     = mdDone;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe; muldiv scenarios run only when ALU_CTRL_MULDIV_EN is defined.
module tb_alu_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] aluop = 3'b000;
    logic [5:0] funct = 6'b000000;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alucontrol;
    logic       shift_var;
    logic       is_unsigned;
    logic       illegal;
    logic       md_busy;
    logic       md_done;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] ctrl;
        logic       sv;
        logic       us;
        logic       il;
    } vec_t;

    alu_ctrl_pipe #(.ALUOP_W(3), .MULT_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alucontrol(alucontrol), .shift_var(shift_var),
        .is_unsigned(is_unsigned), .illegal(illegal), .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol, shift_var, is_unsigned, illegal} !== 8'b0_0000_000)
            $display("[TB] FAIL reset_out got %b want %b",
                     {out_valid, alucontrol, shift_var, is_unsigned, illegal}, 8'b0);
        else passes++;
        checks++;
        if ({md_busy, md_done} !== 2'b00)
            $display("[TB] FAIL reset_md got %b want 00", {md_busy, md_done});
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        vec_t v[17];
        v[0]  = '{3'b010, 6'b100111, 4'b0100, 1'b0, 1'b0, 1'b0};
        v[1]  = '{3'b010, 6'b000110, 4'b1010, 1'b1, 1'b0, 1'b0};
        v[2]  = '{3'b110, 6'b000000, 4'b1100, 1'b0, 1'b0, 1'b0};
        v[3]  = '{3'b010, 6'b111111, 4'b0101, 1'b0, 1'b0, 1'b1};
        v[4]  = '{3'b000, 6'b101011, 4'b0010, 1'b0, 1'b0, 1'b0};
        v[5]  = '{3'b001, 6'b000000, 4'b0110, 1'b0, 1'b0, 1'b0};
        v[6]  = '{3'b011, 6'b000000, 4'b0000, 1'b0, 1'b0, 1'b0};
        v[7]  = '{3'b100, 6'b000000, 4'b0001, 1'b0, 1'b0, 1'b0};
        v[8]  = '{3'b101, 6'b000000, 4'b0111, 1'b0, 1'b0, 1'b0};
        v[9]  = '{3'b111, 6'b000000, 4'b0011, 1'b0, 1'b0, 1'b0};
        v[10] = '{3'b010, 6'b101011, 4'b1000, 1'b0, 1'b1, 1'b0};
        v[11] = '{3'b010, 6'b000011, 4'b1011, 1'b0, 1'b0, 1'b0};
        v[12] = '{3'b010, 6'b000100, 4'b1001, 1'b1, 1'b0, 1'b0};
        v[13] = '{3'b010, 6'b100001, 4'b0010, 1'b0, 1'b0, 1'b0};
        v[14] = '{3'b010, 6'b100010, 4'b0110, 1'b0, 1'b0, 1'b0};
        v[15] = '{3'b010, 6'b101010, 4'b0111, 1'b0, 1'b0, 1'b0};
        v[16] = '{3'b010, 6'b000010, 4'b1010, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            aluop    = v[i].op;
            funct    = v[i].fn;
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) $display("[TB] FAIL decode_in_ready[%0d] got %b want 1", i, in_ready);
            else passes++;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, alucontrol, shift_var, is_unsigned, illegal} !==
                {1'b1, v[i].ctrl, v[i].sv, v[i].us, v[i].il})
                $display("[TB] FAIL decode[%0d] got %b want %b", i,
                         {out_valid, alucontrol, shift_var, is_unsigned, illegal},
                         {1'b1, v[i].ctrl, v[i].sv, v[i].us, v[i].il});
            else passes++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL decode_drain got %b want 0", out_valid);
        else passes++;
    endtask

    task automatic test_back_pressure();
        @(negedge clk);
        out_ready = 1'b0;
        aluop     = 3'b000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol} !== 5'b1_0010)
            $display("[TB] FAIL bp_add got %b want 10010", {out_valid, alucontrol});
        else passes++;
        @(negedge clk);
        aluop = 3'b001;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL bp_stall got %b want 0", in_ready);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, alucontrol} !== 5'b1_0010)
                $display("[TB] FAIL bp_hold[%0d] got %b want 10010", i, {out_valid, alucontrol});
            else passes++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL bp_release got %b want 1", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol} !== 5'b1_0110)
            $display("[TB] FAIL bp_sub got %b want 10110", {out_valid, alucontrol});
        else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL bp_clear got %b want 0", out_valid);
        else passes++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        aluop     = 3'b111;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol} !== 5'b1_0011)
            $display("[TB] FAIL flush_load got %b want 10011", {out_valid, alucontrol});
        else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL flush_held got %b want 0", out_valid);
        else passes++;
        @(negedge clk);
        out_ready = 1'b1;
        aluop     = 3'b100;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready got %b want 0", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL flush_override got %b want 0", out_valid);
        else passes++;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

`ifdef ALU_CTRL_MULDIV_EN
    task automatic test_muldiv();
        @(negedge clk);
        out_ready = 1'b1;
        aluop     = 3'b010;
        funct     = 6'b011001;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol, is_unsigned} !== 6'b1_1101_1)
            $display("[TB] FAIL md_multu got %b want 111011", {out_valid, alucontrol, is_unsigned});
        else passes++;
        @(negedge clk);
        funct = 6'b010010;
        #1;
        checks++;
        if ({in_ready, md_busy} !== 2'b00)
            $display("[TB] FAIL md_T got %b want 00", {in_ready, md_busy});
        else passes++;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({in_ready, md_busy, md_done} !== {1'b0, 1'b1, (k == 4)})
                $display("[TB] FAIL md_busy[T+%0d] got %b want %b", k,
                         {in_ready, md_busy, md_done}, {1'b0, 1'b1, (k == 4)});
            else passes++;
        end
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, md_busy, md_done} !== 3'b100)
            $display("[TB] FAIL md_T5 got %b want 100", {in_ready, md_busy, md_done});
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol} !== 5'b1_1111)
            $display("[TB] FAIL md_mflo got %b want 11111", {out_valid, alucontrol});
        else passes++;
        @(negedge clk);
        funct = 6'b011000;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol} !== 5'b1_1101)
            $display("[TB] FAIL md_mult got %b want 11101", {out_valid, alucontrol});
        else passes++;
        @(negedge clk);
        aluop = 3'b000;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL md_add_ready got %b want 1", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol, md_busy} !== 6'b1_0010_1)
            $display("[TB] FAIL md_add_busy got %b want 100101", {out_valid, alucontrol, md_busy});
        else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b0) $display("[TB] FAIL md_drain got %b want 0", md_busy);
        else passes++;
    endtask

    task automatic test_muldiv_flush();
        @(negedge clk);
        out_ready = 1'b0;
        aluop     = 3'b010;
        funct     = 6'b011010;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol} !== 5'b1_1110)
            $display("[TB] FAIL mdf_div got %b want 11110", {out_valid, alucontrol});
        else passes++;
        @(negedge clk);
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, md_busy} !== 2'b00)
            $display("[TB] FAIL mdf_flushed got %b want 00", {out_valid, md_busy});
        else passes++;
        @(negedge clk);
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b0) $display("[TB] FAIL mdf_nostart got %b want 0", md_busy);
        else passes++;
        @(negedge clk);
        funct    = 6'b011011;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b1) $display("[TB] FAIL mdf_busy1 got %b want 1", md_busy);
        else passes++;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({md_busy, md_done} !== 2'b10)
            $display("[TB] FAIL mdf_busy10 got %b want 10", {md_busy, md_done});
        else passes++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({md_busy, md_done} !== 2'b00)
            $display("[TB] FAIL mdf_reset got %b want 00", {md_busy, md_done});
        else passes++;
        @(negedge clk);
        rst_n    = 1'b1;
        funct    = 6'b010000;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL mdf_mfhi_ready got %b want 1", in_ready);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask
`else
    task automatic test_no_muldiv();
        @(negedge clk);
        out_ready = 1'b1;
        aluop     = 3'b010;
        funct     = 6'b011000;
        in_valid  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL nomd_ready got %b want 1", in_ready);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol, illegal, md_busy} !== 7'b1_0101_1_0)
            $display("[TB] FAIL nomd_mult got %b want 1010110", {out_valid, alucontrol, illegal, md_busy});
        else passes++;
        @(negedge clk);
        funct = 6'b010000;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, alucontrol, illegal} !== 6'b1_0101_1)
            $display("[TB] FAIL nomd_mfhi got %b want 101011", {out_valid, alucontrol, illegal});
        else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({md_busy, md_done} !== 2'b00)
            $display("[TB] FAIL nomd_idle got %b want 00", {md_busy, md_done});
        else passes++;
    endtask
`endif

    initial begin
        $display("[TB] starting alu_ctrl_pipe bench");
        test_reset();
        test_decode();
        test_back_pressure();
        test_flush();
`ifdef ALU_CTRL_MULDIV_EN
        test_muldiv();
        test_muldiv_flush();
`else
        test_no_muldiv();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
